// File: rtl/lut_coeff_ram.sv
// Single-port synchronous coefficient RAM for the tanh slope/intercept tables.
// Contents reload from INIT_BASE/INIT_STEP on reset; selectable write mode.
module lut_coeff_ram #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_BASE  = 32'h0001_0000,
    parameter logic [DATA_W-1:0] INIT_STEP  = 32'hFFFF_F800,
    parameter int                WRITE_MODE = 0
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              ena,
    input  logic [0:0]        wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam int MODE_WRITE_FIRST = 0;
    localparam int MODE_READ_FIRST  = 1;
    localparam int MODE_NO_CHANGE   = 2;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] init_word(input int idx);
        logic [DATA_W-1:0] k;
        k = DATA_W'(idx);
        return INIT_BASE + k * INIT_STEP;
    endfunction

    logic do_write;
    logic do_read;

    assign do_write = ena & wea[0];
    assign do_read  = ena & ~wea[0];

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= init_word(i);
            end
        end else if (do_write) begin
            mem[addra] <= dina;
        end
    end

    // The old word is sampled in the same edge as the write, so read-first
    // sees pre-write contents without any bypass.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            douta <= '0;
        end else if (do_read) begin
            douta <= mem[addra];
        end else if (do_write) begin
            case (WRITE_MODE)
                MODE_WRITE_FIRST: douta <= dina;
                MODE_READ_FIRST:  douta <= mem[addra];
                MODE_NO_CHANGE:   douta <= douta;
                default:          douta <= douta;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_coeff_ram.sv
// Directed bench for lut_coeff_ram; three instances cover all write modes.
// Shared stimulus, per-mode expectations computed by hand.
module tb_lut_coeff_ram;

    logic        clka;
    logic        rsta;
    logic        ena;
    logic [0:0]  wea;
    logic [4:0]  addra;
    logic [31:0] dina;
    logic [31:0] dout [3];

    int checks;
    int errors;

    lut_coeff_ram #(.WRITE_MODE(0)) u_wf (
        .clka(clka), .rsta(rsta), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .douta(dout[0])
    );
    lut_coeff_ram #(.WRITE_MODE(1)) u_rf (
        .clka(clka), .rsta(rsta), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .douta(dout[1])
    );
    lut_coeff_ram #(.WRITE_MODE(2)) u_nc (
        .clka(clka), .rsta(rsta), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .douta(dout[2])
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    function automatic logic [31:0] init_val(input int i);
        return 32'h0001_0000 - 32'(i) * 32'h0000_0800;
    endfunction

    task automatic cycle(input logic e, input logic w,
                         input logic [4:0] a, input logic [31:0] d);
        ena   = e;
        wea   = w;
        addra = a;
        dina  = d;
        @(negedge clka);
    endtask

    task automatic test_reset;
        rsta = 1'b1;
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        repeat (2) @(negedge clka);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout[m] !== 32'h0) begin
                $display("FAIL reset_state m%0d: got %h want %h",
                         m, dout[m], 32'h0);
                errors++;
            end
        end
        rsta = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_read;
        logic [4:0]  a [2];
        logic [31:0] e [2];
        a[0] = 5'd0;  e[0] = 32'h0001_0000;
        a[1] = 5'd31; e[1] = 32'h0000_0800;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, a[k], 32'h0);
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (dout[m] !== e[k]) begin
                    $display("FAIL read_init a%0d m%0d: got %h want %h",
                             a[k], m, dout[m], e[k]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_write_modes;
        logic [31:0] e [3];
        // previous douta is word 31 for the no-change instance
        e[0] = 32'hDEAD_BEEF;
        e[1] = 32'h0000_D800;
        e[2] = 32'h0000_0800;
        cycle(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout[m] !== e[m]) begin
                $display("FAIL write_mode m%0d: got %h want %h",
                         m, dout[m], e[m]);
                errors++;
            end
        end
        cycle(1'b1, 1'b0, 5'd5, 32'h0);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout[m] !== 32'hDEAD_BEEF) begin
                $display("FAIL write_readback m%0d: got %h want %h",
                         m, dout[m], 32'hDEAD_BEEF);
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 1'b1, 5'd7, 32'h1234_5678);
        checks++;
        if (dout[2] !== 32'hDEAD_BEEF) begin
            $display("FAIL b2b_nochange_hold: got %h want %h",
                     dout[2], 32'hDEAD_BEEF);
            errors++;
        end
        checks++;
        if (dout[1] !== 32'h0000_C800) begin
            $display("FAIL b2b_readfirst_old: got %h want %h",
                     dout[1], 32'h0000_C800);
            errors++;
        end
        cycle(1'b1, 1'b0, 5'd7, 32'h0);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout[m] !== 32'h1234_5678) begin
                $display("FAIL b2b_read m%0d: got %h want %h",
                         m, dout[m], 32'h1234_5678);
                errors++;
            end
        end
    endtask

    task automatic test_enable;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, k[0], 5'(k), 32'hA5A5_0000 + 32'(k));
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (dout[m] !== 32'h1234_5678) begin
                    $display("FAIL ena_frozen k%0d m%0d: got %h want %h",
                             k, m, dout[m], 32'h1234_5678);
                    errors++;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 5'(k), 32'h0);
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (dout[m] !== init_val(k)) begin
                    $display("FAIL ena_nowrite a%0d m%0d: got %h want %h",
                             k, m, dout[m], init_val(k));
                    errors++;
                end
            end
        end
    endtask

    task automatic test_async_reset;
        cycle(1'b1, 1'b1, 5'd5, 32'hCAFE_F00D);
        @(posedge clka);
        #2;
        rsta = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout[m] !== 32'h0) begin
                $display("FAIL async_reset m%0d: got %h want %h",
                         m, dout[m], 32'h0);
                errors++;
            end
        end
        @(negedge clka);
        cycle(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF);
        rsta = 1'b0;
        checks++;
        if (dout[0] !== 32'h0) begin
            $display("FAIL reset_dominates: got %h want %h",
                     dout[0], 32'h0);
            errors++;
        end
        cycle(1'b1, 1'b0, 5'd5, 32'h0);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout[m] !== 32'h0000_D800) begin
                $display("FAIL reset_restore5 m%0d: got %h want %h",
                         m, dout[m], 32'h0000_D800);
                errors++;
            end
        end
        cycle(1'b1, 1'b0, 5'd7, 32'h0);
        checks++;
        if (dout[0] !== 32'h0000_C800) begin
            $display("FAIL reset_restore7: got %h want %h",
                     dout[0], 32'h0000_C800);
            errors++;
        end
        cycle(1'b1, 1'b0, 5'd9, 32'h0);
        checks++;
        if (dout[0] !== init_val(9)) begin
            $display("FAIL reset_restore9: got %h want %h",
                     dout[0], init_val(9));
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read();
        test_write_modes();
        test_back_to_back();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
